// File: rtl/change_dispenser.sv
`default_nettype none
// ============================================================================
// Module   : change_dispenser
// Purpose  : Pays out a change amount (Rs 0-31) as coins using a greedy
//            Rs10/Rs5/Rs2/Rs1 breakdown, limited by per-denomination
//            inventory. Coins go to the hopper one at a time over a
//            valid/ready handshake. Any amount that cannot be paid is
//            reported as a shortfall.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk, rst           clock; asynchronous active-high reset
//   i_req_valid        change request strobe (taken only when o_req_ready=1)
//   i_req_amount[4:0]  change to pay
//   o_req_ready        high in IDLE only
//   o_coin_out[2:0]    coin code offered (001=Rs1 010=Rs2 011=Rs5 100=Rs10),
//                      000 when o_coin_valid=0
//   o_coin_valid       coin offered to the hopper
//   i_hopper_ready     hopper accepts the offered coin this cycle
//   o_done             1-cycle pulse, request finished
//   o_shortfall[4:0]   unpaid amount, valid with o_done, held until next done
//   o_busy             ~o_req_ready
//   i_refill_en        add i_refill_qty coins of i_refill_coin this cycle
//   i_refill_coin[2:0] denomination code to refill; other codes ignored
//   i_refill_qty       coins to add (saturating)
//   o_cnt_rs1/2/5/10   current inventory per denomination
// ============================================================================
module change_dispenser #(
  parameter int CNT_W      = 8,
  parameter int INIT_COUNT = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_req_valid,
  input  logic [4:0]       i_req_amount,
  output logic             o_req_ready,
  output logic [2:0]       o_coin_out,
  output logic             o_coin_valid,
  input  logic             i_hopper_ready,
  output logic             o_done,
  output logic [4:0]       o_shortfall,
  output logic             o_busy,
  input  logic             i_refill_en,
  input  logic [2:0]       i_refill_coin,
  input  logic [CNT_W-1:0] i_refill_qty,
  output logic [CNT_W-1:0] o_cnt_rs1,
  output logic [CNT_W-1:0] o_cnt_rs2,
  output logic [CNT_W-1:0] o_cnt_rs5,
  output logic [CNT_W-1:0] o_cnt_rs10
);

  localparam logic [CNT_W:0] c_CNT_MAX = {1'b0, {CNT_W{1'b1}}};

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SELECT = 2'd1,
    S_EJECT  = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t                r_state, w_state_nxt;
  logic [4:0]            r_remaining, w_remaining_nxt;
  logic [2:0]            r_coin, w_coin_nxt;
  logic [4:0]            r_shortfall, w_shortfall_nxt;
  // Inventory index: 0=Rs1, 1=Rs2, 2=Rs5, 3=Rs10 (index = coin code - 1)
  logic [3:0][CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [3:0]            w_dec;
  logic [3:0]            w_refill;

  function automatic logic [4:0] coin_value(input logic [2:0] code);
    case (code)
      3'b001:  coin_value = 5'd1;
      3'b010:  coin_value = 5'd2;
      3'b011:  coin_value = 5'd5;
      3'b100:  coin_value = 5'd10;
      default: coin_value = 5'd0;
    endcase
  endfunction

  // Refill decode: codes 000 and 101-111 map to no denomination.
  always_comb begin
    w_refill = 4'b0000;
    if (i_refill_en) begin
      case (i_refill_coin)
        3'b001:  w_refill = 4'b0001;
        3'b010:  w_refill = 4'b0010;
        3'b011:  w_refill = 4'b0100;
        3'b100:  w_refill = 4'b1000;
        default: w_refill = 4'b0000;
      endcase
    end
  end

  // Next-state / datapath control
  always_comb begin
    w_state_nxt     = r_state;
    w_remaining_nxt = r_remaining;
    w_coin_nxt      = r_coin;
    w_shortfall_nxt = r_shortfall;
    w_dec           = 4'b0000;
    case (r_state)
      S_IDLE: begin
        if (i_req_valid) begin
          w_remaining_nxt = i_req_amount;
          if (i_req_amount != 5'd0) begin
            w_state_nxt = S_SELECT;
          end else begin
            w_state_nxt     = S_DONE;
            w_shortfall_nxt = 5'd0;
          end
        end
      end
      S_SELECT: begin
        // Greedy choice, skipping denominations that are out of stock.
        w_state_nxt = S_EJECT;
        if (r_remaining >= 5'd10 && r_cnt[3] != '0) begin
          w_coin_nxt = 3'b100;
        end else if (r_remaining >= 5'd5 && r_cnt[2] != '0) begin
          w_coin_nxt = 3'b011;
        end else if (r_remaining >= 5'd2 && r_cnt[1] != '0) begin
          w_coin_nxt = 3'b010;
        end else if (r_remaining >= 5'd1 && r_cnt[0] != '0) begin
          w_coin_nxt = 3'b001;
        end else begin
          w_state_nxt     = S_DONE;
          w_shortfall_nxt = r_remaining;
        end
      end
      S_EJECT: begin
        if (i_hopper_ready) begin
          w_remaining_nxt = r_remaining - coin_value(r_coin);
          case (r_coin)
            3'b001:  w_dec = 4'b0001;
            3'b010:  w_dec = 4'b0010;
            3'b011:  w_dec = 4'b0100;
            3'b100:  w_dec = 4'b1000;
            default: w_dec = 4'b0000;
          endcase
          if (w_remaining_nxt == 5'd0) begin
            w_state_nxt     = S_DONE;
            w_shortfall_nxt = 5'd0;
          end else begin
            w_state_nxt = S_SELECT;
          end
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Inventory update: refill and decrement may hit the same counter on the
  // same edge. A decrement only happens on a non-empty counter, so the
  // widened sum never underflows.
  always_comb begin : p_cnt_nxt
    logic [CNT_W:0] v_sum;
    v_sum     = '0;
    w_cnt_nxt = r_cnt;
    for (int i = 0; i < 4; i++) begin
      v_sum = {1'b0, r_cnt[i]}
            + (w_refill[i] ? {1'b0, i_refill_qty} : '0)
            - {{CNT_W{1'b0}}, w_dec[i]};
      w_cnt_nxt[i] = (v_sum > c_CNT_MAX) ? c_CNT_MAX[CNT_W-1:0] : v_sum[CNT_W-1:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_remaining <= 5'd0;
      r_coin      <= 3'b000;
      r_shortfall <= 5'd0;
      for (int i = 0; i < 4; i++) begin
        r_cnt[i] <= CNT_W'(INIT_COUNT);
      end
    end else begin
      r_state     <= w_state_nxt;
      r_remaining <= w_remaining_nxt;
      r_coin      <= w_coin_nxt;
      r_shortfall <= w_shortfall_nxt;
      r_cnt       <= w_cnt_nxt;
    end
  end

  assign o_req_ready  = (r_state == S_IDLE);
  assign o_busy       = ~o_req_ready;
  assign o_coin_valid = (r_state == S_EJECT);
  assign o_coin_out   = o_coin_valid ? r_coin : 3'b000;
  assign o_done       = (r_state == S_DONE);
  assign o_shortfall  = r_shortfall;
  assign o_cnt_rs1    = r_cnt[0];
  assign o_cnt_rs2    = r_cnt[1];
  assign o_cnt_rs5    = r_cnt[2];
  assign o_cnt_rs10   = r_cnt[3];

endmodule
`default_nettype wire

// File: tb/tb_change_dispenser.sv
`default_nettype none
// ============================================================================
// Module   : tb_change_dispenser
// Purpose  : Directed self-checking bench for change_dispenser. Expected
//            coin sequences, latencies, shortfalls and inventory levels are
//            hand-computed constants.
// Revision : 1.0 - initial release
// ============================================================================
module tb_change_dispenser;

  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             i_req_valid;
  logic [4:0]       i_req_amount;
  logic             o_req_ready;
  logic [2:0]       o_coin_out;
  logic             o_coin_valid;
  logic             i_hopper_ready;
  logic             o_done;
  logic [4:0]       o_shortfall;
  logic             o_busy;
  logic             i_refill_en;
  logic [2:0]       i_refill_coin;
  logic [CNT_W-1:0] i_refill_qty;
  logic [CNT_W-1:0] o_cnt_rs1, o_cnt_rs2, o_cnt_rs5, o_cnt_rs10;

  int chk_cnt = 0;
  int err_cnt = 0;

  // Results of the most recent run_req call
  logic [2:0] coins[$];
  int         edges;
  int         stall_bad;
  int         idle_coin_bad;

  change_dispenser #(.CNT_W(CNT_W), .INIT_COUNT(16)) u_dut (
    .clk            (clk),
    .rst            (rst),
    .i_req_valid    (i_req_valid),
    .i_req_amount   (i_req_amount),
    .o_req_ready    (o_req_ready),
    .o_coin_out     (o_coin_out),
    .o_coin_valid   (o_coin_valid),
    .i_hopper_ready (i_hopper_ready),
    .o_done         (o_done),
    .o_shortfall    (o_shortfall),
    .o_busy         (o_busy),
    .i_refill_en    (i_refill_en),
    .i_refill_coin  (i_refill_coin),
    .i_refill_qty   (i_refill_qty),
    .o_cnt_rs1      (o_cnt_rs1),
    .o_cnt_rs2      (o_cnt_rs2),
    .o_cnt_rs5      (o_cnt_rs5),
    .o_cnt_rs10     (o_cnt_rs10)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  function automatic int coin_val(input logic [2:0] c);
    case (c)
      3'b001:  return 1;
      3'b010:  return 2;
      3'b011:  return 5;
      3'b100:  return 10;
      default: return 0;
    endcase
  endfunction

  function automatic logic [31:0] coins_packed();
    logic [31:0] p = '0;
    foreach (coins[i]) p = (p << 3) | {29'd0, coins[i]};
    return p;
  endfunction

  function automatic int coins_sum();
    int s = 0;
    foreach (coins[i]) s += coin_val(coins[i]);
    return s;
  endfunction

  task automatic check_cnts(input string tag, input int c1, input int c2, input int c5, input int c10);
    check_val({tag, "_rs1"},  32'(o_cnt_rs1),  32'(c1));
    check_val({tag, "_rs2"},  32'(o_cnt_rs2),  32'(c2));
    check_val({tag, "_rs5"},  32'(o_cnt_rs5),  32'(c5));
    check_val({tag, "_rs10"}, 32'(o_cnt_rs10), 32'(c10));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic refill(input logic [2:0] code, input logic [CNT_W-1:0] qty);
    @(negedge clk);
    i_refill_en   = 1'b1;
    i_refill_coin = code;
    i_refill_qty  = qty;
    @(posedge clk);
    @(negedge clk);
    i_refill_en   = 1'b0;
    i_refill_coin = 3'b000;
    i_refill_qty  = '0;
  endtask

  // Issues a request and follows it to done. Returns at the negedge where
  // o_done is high. 'edges' counts clock edges from acceptance (inclusive)
  // to the edge that raised done. 'stall' holds hopper_ready low for the
  // first N cycles a coin is offered. 'poke' keeps a second request (Rs5)
  // asserted while busy.
  task automatic run_req(input logic [4:0] amt, input int stall, input bit poke);
    logic [2:0] held;
    int         n;
    coins.delete();
    stall_bad     = 0;
    idle_coin_bad = 0;
    held          = 3'b000;
    n             = stall;
    @(negedge clk);
    i_req_valid  = 1'b1;
    i_req_amount = amt;
    @(posedge clk);
    edges = 1;
    @(negedge clk);
    i_req_valid = poke;
    if (poke) i_req_amount = 5'd5;
    while (!o_done && edges < 200) begin
      if (o_coin_valid) begin
        if (n > 0) begin
          if (n == stall) held = o_coin_out;
          else if (o_coin_out !== held) stall_bad++;
          i_hopper_ready = 1'b0;
          n--;
        end else begin
          if (stall > 0 && coins.size() == 0 && o_coin_out !== held) stall_bad++;
          i_hopper_ready = 1'b1;
          coins.push_back(o_coin_out);
        end
      end else begin
        i_hopper_ready = 1'b1;
        if (o_coin_out !== 3'b000) idle_coin_bad++;
      end
      @(posedge clk);
      edges++;
      @(negedge clk);
    end
    if (!o_done) check_val("done_timeout", 32'(o_done), 32'd1);
    i_req_valid    = 1'b0;
    i_hopper_ready = 1'b1;
  endtask

  initial begin
    rst            = 1'b1;
    i_req_valid    = 1'b0;
    i_req_amount   = 5'd0;
    i_hopper_ready = 1'b1;
    i_refill_en    = 1'b0;
    i_refill_coin  = 3'b000;
    i_refill_qty   = '0;
    do_reset();

    // Reset state
    @(negedge clk);
    check_val("rst_req_ready",  32'(o_req_ready),  32'd1);
    check_val("rst_busy",       32'(o_busy),       32'd0);
    check_val("rst_coin_valid", 32'(o_coin_valid), 32'd0);
    check_val("rst_coin_out",   32'(o_coin_out),   32'd0);
    check_val("rst_done",       32'(o_done),       32'd0);
    check_val("rst_shortfall",  32'(o_shortfall),  32'd0);
    check_cnts("rst", 16, 16, 16, 16);

    // 1: Rs18 -> 10,5,2,1
    run_req(5'd18, 0, 1'b0);
    check_val("t1_coins",     coins_packed(), 32'b100_011_010_001);
    check_val("t1_edges",     32'(edges), 32'd9);
    check_val("t1_shortfall", 32'(o_shortfall), 32'd0);
    check_val("t1_busy_done", 32'(o_busy), 32'd1);
    check_val("t1_idle_coin", 32'(idle_coin_bad), 32'd0);
    check_cnts("t1", 15, 15, 15, 15);

    // 2: drain Rs10 then Rs20 -> four Rs5
    for (int k = 0; k < 15; k++) run_req(5'd10, 0, 1'b0);
    check_val("t2_drain10", 32'(o_cnt_rs10), 32'd0);
    run_req(5'd20, 0, 1'b0);
    check_val("t2_coins",     coins_packed(), 32'b011_011_011_011);
    check_val("t2_shortfall", 32'(o_shortfall), 32'd0);
    check_cnts("t2", 15, 15, 11, 0);

    // 3: drain everything, then Rs3 is unpayable
    run_req(5'd30, 0, 1'b0);
    check_val("t3_n30a", 32'(coins.size()), 32'd6);
    run_req(5'd25, 0, 1'b0);
    check_val("t3_n25", 32'(coins.size()), 32'd5);
    run_req(5'd30, 0, 1'b0);
    check_val("t3_n30b", 32'(coins.size()), 32'd15);
    check_val("t3_sum30b", 32'(coins_sum()), 32'd30);
    run_req(5'd15, 0, 1'b0);
    check_val("t3_n15", 32'(coins.size()), 32'd15);
    check_cnts("t3_empty", 0, 0, 0, 0);
    run_req(5'd3, 0, 1'b0);
    check_val("t3_nocoins",  32'(coins.size()), 32'd0);
    check_val("t3_edges",    32'(edges), 32'd2);
    check_val("t3_shortfall", 32'(o_shortfall), 32'd3);
    repeat (3) @(negedge clk);
    check_val("t3_short_held", 32'(o_shortfall), 32'd3);
    check_val("t3_idle_ready", 32'(o_req_ready), 32'd1);

    // 4: restock, Rs7 with hopper stalled 5 cycles on the first coin
    refill(3'b001, 8'd16);
    refill(3'b010, 8'd16);
    refill(3'b011, 8'd16);
    refill(3'b100, 8'd16);
    check_cnts("t4_refill", 16, 16, 16, 16);
    run_req(5'd7, 5, 1'b0);
    check_val("t4_coins",     coins_packed(), 32'b011_010);
    check_val("t4_sum",       32'(coins_sum()), 32'd7);
    check_val("t4_stable",    32'(stall_bad), 32'd0);
    check_val("t4_edges",     32'(edges), 32'd10);
    check_val("t4_shortfall", 32'(o_shortfall), 32'd0);
    check_cnts("t4", 16, 15, 15, 16);

    // 5: Rs12 with a Rs5 request held while busy (must be ignored)
    run_req(5'd12, 0, 1'b1);
    check_val("t5_coins", coins_packed(), 32'b100_010);
    check_val("t5_edges", 32'(edges), 32'd5);
    @(negedge clk);
    @(negedge clk);
    check_val("t5_no_queue", 32'(o_req_ready), 32'd1);
    check_cnts("t5a", 16, 14, 15, 15);
    run_req(5'd5, 0, 1'b0);
    check_val("t5_retry", coins_packed(), 32'b011);
    refill(3'b101, 8'd9);
    check_cnts("t5_badcode", 16, 14, 14, 15);

    // 6: saturating refill, zero request, reset during eject
    do_reset();
    refill(3'b001, 8'd250);
    check_val("t6_sat", 32'(o_cnt_rs1), 32'd255);
    refill(3'b001, 8'd1);
    check_val("t6_sat2", 32'(o_cnt_rs1), 32'd255);
    run_req(5'd0, 0, 1'b0);
    check_val("t6_zero_edges", 32'(edges), 32'd1);
    check_val("t6_zero_coins", 32'(coins.size()), 32'd0);
    check_val("t6_zero_short", 32'(o_shortfall), 32'd0);

    @(negedge clk);
    i_req_valid    = 1'b1;
    i_req_amount   = 5'd10;
    i_hopper_ready = 1'b0;
    @(negedge clk);
    i_req_valid = 1'b0;
    @(negedge clk);
    check_val("t6_eject_valid", 32'(o_coin_valid), 32'd1);
    check_val("t6_eject_coin",  32'(o_coin_out), 32'b100);
    #2 rst = 1'b1;
    #1;
    check_val("t6_rst_valid", 32'(o_coin_valid), 32'd0);
    check_val("t6_rst_coin",  32'(o_coin_out), 32'd0);
    check_val("t6_rst_ready", 32'(o_req_ready), 32'd1);
    check_cnts("t6_rst", 16, 16, 16, 16);
    @(negedge clk);
    rst            = 1'b0;
    i_hopper_ready = 1'b1;
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", chk_cnt, err_cnt);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
